// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 parity slot, 1 stop bit.
// Oversamples the line with sample_tick, re-arms at mid-stop, and emits a 1-clk rx_valid.
// Output data and flags are registered and hold until the next completed frame.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rx_enable,
    input  logic                  parity_enable,
    input  logic                  rx_data_in,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_sync;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_bit;
    logic                    stop_sample;
    logic                    frame_done;

    // The line is asynchronous to clk; two flops, both idling high like the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_data_in;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM: every step waits for a sample tick, except the rx_enable abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            stop_sample <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && !rx_enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (rx_enable && !rx_sync) begin
                            cnt   <= '0;
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt == CNT_MID) begin
                            // A start bit that is high again at mid-bit was a glitch.
                            if (rx_sync) begin
                                state <= IDLE;
                            end else begin
                                cnt     <= '0;
                                bit_idx <= '0;
                                state   <= DATA;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            shift_reg[bit_idx] <= rx_sync;
                            cnt                <= '0;
                            if (bit_idx == IDX_LAST) begin
                                state <= PARITY;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (cnt == CNT_LAST) begin
                            par_bit <= rx_sync;
                            cnt     <= '0;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Re-arm at mid-stop so a following start edge is not missed.
                        if (cnt == CNT_LAST) begin
                            stop_sample <= rx_sync;
                            frame_done  <= 1'b1;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Publish the frame one clk after the stop sample; data and flags hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_out   <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_done) begin
                rx_data_out   <= shift_reg;
                parity_error  <= parity_enable & ((^shift_reg) != par_bit);
                framing_error <= ~stop_sample;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written corner sequences.
// Frames are driven on the serial line at OVERSAMPLE*tick_div clks per bit.
// Received words are captured by a negedge monitor into a queue and checked against the table.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_enable = 1'b0;
    logic       parity_enable = 1'b0;
    logic       rx_data_in = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    int tests = 0;
    int fails = 0;

    uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .rx_enable    (rx_enable),
        .parity_enable(parity_enable),
        .rx_data_in   (rx_data_in),
        .rx_data_out  (rx_data_out),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Tick generator: one-clk pulse every tick_div clks.
    int tick_div = 1;
    int tick_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            tick_cnt++;
            sample_tick = ((tick_cnt % tick_div) == 0);
        end
    end

    // Monitor: capture every rx_valid cycle, detect stretched pulses, count busy cycles.
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;
    rec_t q[$];
    int   long_pulse = 0;
    int   busy_cycles = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) q.push_back({rx_data_out, parity_error, framing_error});
        if (rx_valid && valid_prev) long_pulse++;
        valid_prev = rx_valid;
        if (busy) busy_cycles++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       pen;
        int         div;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_data_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        int bt;
        bt = 16 * tick_div;
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
        drive_bit(p, bt);
        drive_bit(s, bt);
        rx_data_in = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int n);
        int budget;
        budget = 3000;
        while (q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, got %0d frames, expected %0d", name, q.size(), n);
        end
    endtask

    initial begin
        // Expected parity bits are even parity of the data byte.
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b0, 1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 1'b0, 1'b1, 1'b1, 1, 8'h55, 1'b0, 1'b0};
        vecs[5] = '{8'hFE, 1'b0, 1'b1, 1'b1, 1, 8'hFE, 1'b1, 1'b0};
        vecs[6] = '{8'hFE, 1'b1, 1'b1, 1'b1, 2, 8'hFE, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b1, 1, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 4, 8'h00, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("reset data", 32'(rx_data_out), 32'h0);
        check("reset valid", 32'(rx_valid), 32'h0);
        check("reset perr", 32'(parity_error), 32'h0);
        check("reset ferr", 32'(framing_error), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Ticks with the receiver disabled must not start a frame.
        busy_cycles = 0;
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 20);
        check("disabled no busy", 32'(busy_cycles), 32'h0);
        rx_enable = 1'b1;
        repeat (10) @(negedge clk);

        // Table of single frames.
        for (int i = 0; i < 9; i++) begin
            parity_enable = vecs[i].pen;
            tick_div      = vecs[i].div;
            repeat (8) @(negedge clk);
            q.delete();
            busy_cycles = 0;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            wait_valid($sformatf("v%0d valid", i), 1);
            repeat (8) @(negedge clk);
            if (q.size() >= 1) begin
                check($sformatf("v%0d count", i), 32'(q.size()), 32'd1);
                check($sformatf("v%0d data", i), 32'(q[0].d), 32'(vecs[i].exp_data));
                check($sformatf("v%0d perr", i), 32'(q[0].pe), 32'(vecs[i].exp_pe));
                check($sformatf("v%0d ferr", i), 32'(q[0].fe), 32'(vecs[i].exp_fe));
                check($sformatf("v%0d held", i), 32'(rx_data_out), 32'(vecs[i].exp_data));
            end
            if (i == 0) check("v0 busy ~168", 32'(busy_cycles >= 166 && busy_cycles <= 170), 32'd1);
        end

        // Start glitch: 4 clk low, then high again; last frame was 0x00 with clean flags.
        tick_div = 1;
        parity_enable = 1'b1;
        repeat (20) @(negedge clk);
        q.delete();
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_valid("pre-glitch valid", 1);
        repeat (20) @(negedge clk);
        q.delete();
        busy_cycles = 0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("glitch busy brief", 32'(busy_cycles > 0 && busy_cycles <= 12), 32'd1);
        check("glitch no valid", 32'(q.size()), 32'd0);
        check("glitch busy idle", 32'(busy), 32'd0);
        check("glitch data held", 32'(rx_data_out), 32'h5A);

        // Back-to-back frames with a tick every 4 clk.
        tick_div = 4;
        repeat (8) @(negedge clk);
        q.delete();
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'hFE, 1'b1, 1'b1);
        wait_valid("b2b valid", 2);
        repeat (8) @(negedge clk);
        if (q.size() >= 2) begin
            check("b2b count", 32'(q.size()), 32'd2);
            check("b2b data0", 32'(q[0].d), 32'h12);
            check("b2b data1", 32'(q[1].d), 32'hFE);
            check("b2b flags0", 32'({q[0].pe, q[0].fe}), 32'd0);
            check("b2b flags1", 32'({q[1].pe, q[1].fe}), 32'd0);
        end

        // Reset after data bit 3 of 0x99 (LSB first: 1,0,0,1).
        tick_div = 1;
        repeat (8) @(negedge clk);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 4);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid reset data", 32'(rx_data_out), 32'h0);
        check("mid reset valid", 32'(rx_valid), 32'h0);
        check("mid reset flags", 32'({parity_error, framing_error}), 32'h0);
        check("mid reset busy", 32'(busy), 32'h0);
        rx_data_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        q.delete();
        send_frame(8'h99, 1'b0, 1'b1);
        wait_valid("post-reset valid", 1);
        if (q.size() >= 1) begin
            check("post-reset data", 32'(q[0].d), 32'h99);
            check("post-reset flags", 32'({q[0].pe, q[0].fe}), 32'h0);
        end

        // Abort by dropping rx_enable mid-frame.
        repeat (20) @(negedge clk);
        q.delete();
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        check("pre-abort busy", 32'(busy), 32'd1);
        rx_enable = 1'b0;
        @(negedge clk);
        check("abort idle", 32'(busy), 32'd0);
        rx_data_in = 1'b1;
        repeat (4) @(negedge clk);
        rx_enable = 1'b1;
        repeat (200) @(negedge clk);
        check("abort no valid", 32'(q.size()), 32'd0);
        check("abort data held", 32'(rx_data_out), 32'h99);

        check("valid pulse width", 32'(long_pulse), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
